// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the main memory responder: FSM state encoding,
// block/word geometry and the block-index helper.
package main_memory_responder_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam int BLOCK_W         = 128;
   localparam int WORD_W          = 32;
   localparam int WORDS_PER_BLOCK = 4;

   // Block index of a word address: drop the two word-within-block bits.
   function automatic logic [31:0] block_index(input logic [31:0] word_addr);
      return word_addr >> 2;
   endfunction

endpackage

// File: rtl/main_memory_array.sv
// Word storage for the main memory responder: one synchronous write port
// and one combinational read port returning a whole four-word block.
// Contents have no reset value and survive the responder's reset.
module main_memory_array
   import main_memory_responder_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [WORD_W-1:0]   wdata,
   input  logic [ADDR_W-3:0]   rblk,
   output logic [BLOCK_W-1:0]  rblock
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   // Single-word write, committed on the clock edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Block read: word w of the block lands in bits [w*32 +: 32].
   for (genvar w = 0; w < WORDS_PER_BLOCK; w++) begin : g_rd
      assign rblock[w*WORD_W +: WORD_W] = mem[{rblk, 2'(w)}];
   end

endmodule

// File: rtl/main_memory_responder.sv
// Main memory responder: serves block reads (cache misses) and single-word
// write-throughs after a fixed LATENCY-cycle delay, signalling completion
// with a one-cycle ready pulse. Writes win over simultaneous reads.
// Optional feature: define MAIN_MEMORY_STATS_EN to add rd_count/wr_count
// 16-bit completion counters.
module main_memory_responder
   import main_memory_responder_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rd_req,
   input  logic                wr_req,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [WORD_W-1:0]   wr_data,
   output logic                busy,
   output logic                ready,
   output logic [BLOCK_W-1:0]  mem_block
`ifdef MAIN_MEMORY_STATS_EN
   ,
   output logic [15:0]         rd_count,
   output logic [15:0]         wr_count
`endif
);

   localparam int         BLK_W    = ADDR_W - 2;
   localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [WORD_W-1:0]   data_q;
   logic                accept;
   logic                do_rd;
   logic                do_wr;
   logic [ADDR_W-1:0]   op_addr;
   logic [WORD_W-1:0]   op_data;
   logic [BLK_W-1:0]    rd_blk;
   logic [BLOCK_W-1:0]  rd_block;

   // Next-state, wait counter and completion strobes. In IDLE the live
   // inputs are the operation's address/data, so the LATENCY=1 path can
   // complete on the accepting edge itself.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      do_rd   = 1'b0;
      do_wr   = 1'b0;
      op_addr = addr_q;
      op_data = data_q;
      case (state_q)
         IDLE: begin
            op_addr = addr;
            op_data = wr_data;
            if (wr_req || rd_req) begin
               accept = 1'b1;
               cnt_d  = LAT_INIT;
               if (LATENCY == 1) begin
                  state_d = RESP;
                  do_wr   = wr_req;
                  do_rd   = !wr_req;
               end else begin
                  state_d = wr_req ? WR_WAIT : RD_WAIT;
               end
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = RESP;
               do_rd   = (state_q == RD_WAIT);
               do_wr   = (state_q == WR_WAIT);
            end else begin
               cnt_d = 4'(cnt_q - 4'd1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state and wait counter; reset drops any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request address/data captured at the accepting edge (datapath, no reset).
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= addr;
         data_q <= wr_data;
      end
   end

   // Read block registered on entry to RESP; held until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_block <= '0;
      end else if (do_rd) begin
         mem_block <= rd_block;
      end
   end

   assign rd_blk = BLK_W'(block_index(32'(op_addr)));
   assign busy   = (state_q != IDLE);
   assign ready  = (state_q == RESP);

   // Write enable is gated by reset so a held request cannot commit while
   // the responder is being reset.
   main_memory_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk    (clk),
      .we     (do_wr && rst_n),
      .waddr  (op_addr),
      .wdata  (op_data),
      .rblk   (rd_blk),
      .rblock (rd_block)
   );

`ifdef MAIN_MEMORY_STATS_EN
   // Completion counters, stepped as each read/write enters RESP; wrap at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else begin
         if (do_rd) begin
            rd_count <= rd_count + 16'd1;
         end
         if (do_wr) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end
`endif

endmodule
